start_sequencer: RTL and testbench

- Upstream front-end for the ones-counting control/datapath pair.
- Turns a raw push-button and operand switches into a clean, debounced `start` level and a stable operand `A_out`.
- Holds `start` for the full control handshake: raised to begin, held through `done`, dropped only after button release.
- Also counts completed runs.

---
 rtl/start_seq_pkg.sv | 15 +
 rtl/key_debounce.sv | 48 ++++
 rtl/start_sequencer.sv | 81 ++++++++
 tb/tb_start_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/start_seq_pkg.sv
// rtl/start_seq_pkg.sv - shared types and default sizes for the start sequencer
package start_seq_pkg;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int RUNS_WIDTH              = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_REL = 2'd2
  } seq_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer and debounce filter
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_sync;
  logic                   clean_q, clean_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign key_sync  = sync_q[SYNC_STAGES-1];
  assign key_clean = clean_q;

  // The counter only runs while the synchronized key disagrees with the filtered level.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (key_sync != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = key_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_raw};
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/start_sequencer.sv
// rtl/start_sequencer.sv - debounced start handshake and operand latch for the ones-counter
module start_sequencer
  import start_seq_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_raw,
  input  logic [WIDTH-1:0]      sw_in,
  input  logic                  done,
  output logic                  start,
  output logic [WIDTH-1:0]      A_out,
  output logic                  busy,
  output logic [RUNS_WIDTH-1:0] runs
);

  seq_state_e            state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [RUNS_WIDTH-1:0] runs_q, runs_d;
  logic                  key_clean;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_raw),
    .key_clean (key_clean)
  );

  // A_out stops following the switches on the same edge that leaves IDLE,
  // so it matches what the datapath loads when start rises.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    runs_d  = runs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_clean) begin
          state_d = ST_RUN;
        end else begin
          a_d = sw_in;
        end
      end
      ST_RUN: begin
        if (done) begin
          runs_d  = runs_q + RUNS_WIDTH'(1);
          state_d = key_clean ? ST_WAIT_REL : ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        if (!key_clean) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      runs_q  <= runs_d;
    end
  end

  assign start = (state_q != ST_IDLE);
  assign busy  = (state_q != ST_IDLE);
  assign A_out = a_q;
  assign runs  = runs_q;

endmodule

// File: tb/tb_start_sequencer.sv
// tb/tb_start_sequencer.sv - randomized and directed checks of start_sequencer against a reference model
module tb_start_sequencer;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;

  logic             clk;
  logic             reset;
  logic             key_raw;
  logic [WIDTH-1:0] sw_in;
  logic             done;
  logic             start;
  logic [WIDTH-1:0] A_out;
  logic             busy;
  logic [7:0]       runs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw-sample history, disagreement streak, and a run phase
  bit               m_hist[$];
  int               m_streak;
  bit               m_clean;
  int               m_phase;   // 0 idle, 1 running, 2 waiting for release
  logic [WIDTH-1:0] m_a;
  int               m_runs;

  start_sequencer #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_raw),
    .sw_in   (sw_in),
    .done    (done),
    .start   (start),
    .A_out   (A_out),
    .busy    (busy),
    .runs    (runs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_streak = 0;
    m_clean  = 1'b0;
    m_phase  = 0;
    m_a      = '0;
    m_runs   = 0;
  endtask

  task automatic model_edge();
    bit seen;
    bit new_clean;
    seen      = m_hist[0];
    new_clean = m_clean;
    m_hist.push_back(key_raw);
    void'(m_hist.pop_front());
    if (seen != m_clean) begin
      m_streak++;
      if (m_streak == DEB) begin
        new_clean = seen;
        m_streak  = 0;
      end
    end else begin
      m_streak = 0;
    end
    case (m_phase)
      0: if (m_clean) m_phase = 1; else m_a = sw_in;
      1: if (done) begin
           m_runs  = (m_runs + 1) % 256;
           m_phase = m_clean ? 2 : 0;
         end
      default: if (!m_clean) m_phase = 0;
    endcase
    m_clean = new_clean;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_start"}, 32'(start), 32'(m_phase != 0));
    check({tag, "_busy"},  32'(busy),  32'(m_phase != 0));
    check({tag, "_aout"},  32'(A_out), 32'(m_a));
    check({tag, "_runs"},  32'(runs),  32'(m_runs));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset) model_edge();
    #1;
    compare_model(tag);
    @(negedge clk);
  endtask

  initial begin
    int len;
    logic [WIDTH-1:0] sw_prev;

    reset   = 1'b0;
    key_raw = 1'b0;
    sw_in   = '0;
    done    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_aout",  32'(A_out), 32'd0);
    check("rst_runs",  32'(runs),  32'd0);
    reset = 1'b1;

    // press held: start rises on edge 7, operand frozen at 0x55
    key_raw = 1'b1;
    sw_in   = 8'h55;
    for (int e = 1; e <= 20; e++) begin
      if (e == 8) sw_in = 8'hFF;
      step("t1");
      check("t1_start_edge", 32'(start), 32'(e >= 7));
      check("t1_aout_55",    32'(A_out), 32'h55);
    end

    // done while key held: go to WAIT_REL, second done cycle ignored
    done = 1'b1;
    step("t3");
    check("t3_start_hold", 32'(start), 32'd1);
    check("t3_runs_one",   32'(runs),  32'd1);
    step("t3");
    check("t3_runs_still", 32'(runs),  32'd1);
    done    = 1'b0;
    key_raw = 1'b0;
    sw_in   = 8'h0F;
    for (int e = 1; e <= 10; e++) begin
      step("t3r");
      check("t3_fall_edge", 32'(start), 32'(e < 7));
      if (e >= 8) check("t3_aout_track", 32'(A_out), 32'h0F);
      else        check("t3_aout_frozen", 32'(A_out), 32'h55);
    end

    // glitch shorter than the debounce window
    for (int e = 1; e <= 16; e++) begin
      key_raw = (e <= 3);
      sw_in   = 8'($urandom);
      sw_prev = sw_in;
      step("t2");
      check("t2_start_low", 32'(start), 32'd0);
      check("t2_aout_track", 32'(A_out), 32'(sw_prev));
    end

    // release before done: RUN waits for done, then drops on that edge
    key_raw = 1'b1;
    for (int e = 1; e <= 7; e++) step("t4p");
    check("t4_started", 32'(start), 32'd1);
    key_raw = 1'b0;
    for (int e = 1; e <= 10; e++) step("t4r");
    check("t4_still_run", 32'(start), 32'd1);
    done = 1'b1;
    step("t4d");
    done = 1'b0;
    check("t4_start_off", 32'(start), 32'd0);
    check("t4_busy_off",  32'(busy),  32'd0);
    check("t4_runs_two",  32'(runs),  32'd2);

    // asynchronous reset in the middle of a run
    key_raw = 1'b1;
    for (int e = 1; e <= 8; e++) step("t5p");
    check("t5_in_run", 32'(start), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check("t5_async_start", 32'(start), 32'd0);
    check("t5_async_aout",  32'(A_out), 32'd0);
    check("t5_async_runs",  32'(runs),  32'd0);
    @(negedge clk);
    key_raw = 1'b0;
    for (int e = 1; e <= 3; e++) step("t5rst");
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step("t5idle");
      check("t5_idle", 32'(start), 32'd0);
    end

    // 256 full runs wrap the counter
    for (int r = 1; r <= 256; r++) begin
      key_raw = 1'b1;
      sw_in   = 8'($urandom);
      for (int e = 1; e <= 8; e++) step("t6p");
      done = 1'b1;
      step("t6d");
      done    = 1'b0;
      key_raw = 1'b0;
      for (int e = 1; e <= 8; e++) step("t6r");
      check("t6_idle_after", 32'(start), 32'd0);
      if (r == 255) check("t6_runs_255", 32'(runs), 32'd255);
      if (r == 256) check("t6_runs_wrap", 32'(runs), 32'd0);
    end

    // random bursts of key activity, done pulses and switch changes
    len = 1;
    for (int c = 0; c < 3000; c++) begin
      len--;
      if (len <= 0) begin
        key_raw = ~key_raw;
        len     = $urandom_range(1, 12);
      end
      done  = ($urandom_range(0, 5) == 0);
      sw_in = 8'($urandom);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
